// File: rtl/sprite_cmd_scheduler.sv
// Sprite command scheduler: buffers Avalon command writes in a FIFO, issues one per cycle on the
// broadcast bus, and holds flip requests until vertical blank. Optional status read: SCHED_STATUS_READ_EN.
module sprite_cmd_scheduler #(
    parameter int         FIFO_DEPTH  = 16,
    parameter logic [9:0] VBLANK_LINE = 10'd480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [31:0] writedata,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic [31:0] cmd_out,
    output logic        front_buf,
    output logic        flip_pending
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLIP_WAIT,
        S_FLIP_ISSUE
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   level;
    logic            full, empty, push, pop;
    logic [31:0]     head, cmd_d, flush_word;
    logic            head_is_flip, vblank_start, flip_set, flip_fire;

    assign full         = (level == LW'(FIFO_DEPTH));
    assign empty        = (level == '0);
    assign waitrequest  = full;
    // Writes are refused whenever full, even if a pop frees a slot this cycle.
    assign push         = chipselect && write && !full;
    assign head         = mem[rd_ptr];
    assign head_is_flip = (head[20:17] == 4'hF);
    assign vblank_start = (vcount == VBLANK_LINE) && (hcount == 10'd0);
    assign flush_word   = {6'b0, 5'b0, 4'hF, 3'b0, ~front_buf, 13'b0};

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d   = state_q;
        cmd_d     = 32'h0;
        pop       = 1'b0;
        flip_set  = 1'b0;
        flip_fire = 1'b0;
        case (state_q)
            S_IDLE, S_FLIP_ISSUE: begin
                // The flush cycle also pops, so the word behind a flip follows it immediately.
                state_d = S_IDLE;
                if (!empty) begin
                    pop = 1'b1;
                    if (head_is_flip) begin
                        flip_set = 1'b1;
                        state_d  = S_FLIP_WAIT;
                    end else begin
                        cmd_d = head;
                    end
                end
            end
            S_FLIP_WAIT: begin
                if (vblank_start) begin
                    cmd_d     = flush_word;
                    flip_fire = 1'b1;
                    state_d   = S_FLIP_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cmd_out      <= 32'h0;
            front_buf    <= 1'b0;
            flip_pending <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
        end else begin
            state_q <= state_d;
            cmd_out <= cmd_d;
            if (flip_fire) front_buf <= ~front_buf;
            if (flip_set)
                flip_pending <= 1'b1;
            else if (flip_fire)
                flip_pending <= 1'b0;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; occupancy is tracked by level and pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= writedata;
    end

`ifdef SCHED_STATUS_READ_EN
    logic [31:0] status_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            status_q <= 32'h0;
        else if (chipselect && read)
            status_q <= {16'b0, 6'b0, flip_pending, front_buf, 8'(level)};
    end

    assign readdata = status_q;
`else
    logic unused_read;

    assign unused_read = read;
    assign readdata    = 32'h0;
`endif

endmodule

// File: tb/tb_sprite_cmd_scheduler.sv
// Self-checking bench for sprite_cmd_scheduler: vector table, hand-written flip/full/reset sequences,
// and a scoreboard queue that checks every nonzero word seen on the command bus in order.
module tb_sprite_cmd_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        chipselect = 1'b0, write = 1'b0, read = 1'b0;
    logic [31:0] writedata = 32'h0;
    logic [9:0]  hcount = 10'd5, vcount = 10'd100;
    logic        waitrequest, front_buf, flip_pending;
    logic [31:0] readdata, cmd_out;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] sb[$];
    logic        mdl_front = 1'b0;
    logic [31:0] exp_status;

    typedef struct {
        logic [31:0] wdata;
        logic [31:0] exp_cmd;
    } vec_t;

    localparam int NVEC = 6;
    vec_t tbl[NVEC];

    sprite_cmd_scheduler #(.FIFO_DEPTH(16), .VBLANK_LINE(10'd480)) dut (
        .clk         (clk),
        .reset       (reset),
        .chipselect  (chipselect),
        .write       (write),
        .read        (read),
        .writedata   (writedata),
        .hcount      (hcount),
        .vcount      (vcount),
        .waitrequest (waitrequest),
        .readdata    (readdata),
        .cmd_out     (cmd_out),
        .front_buf   (front_buf),
        .flip_pending(flip_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_write(input logic [31:0] w);
        chipselect = 1'b1;
        write      = 1'b1;
        writedata  = w;
    endtask

    task automatic idle_bus();
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
    endtask

    task automatic restore_timing();
        vcount = 10'd100;
        hcount = 10'd5;
    endtask

    // Drives vblank_start for one cycle; returns one cycle later.
    task automatic pulse_vblank();
        vcount = 10'd480;
        hcount = 10'd0;
        step();
        hcount = 10'd1;
    endtask

    // Expected flush word for a flip issued while the model buffer is fb, then the model toggles.
    task automatic expect_flip();
        sb.push_back({11'b0, 4'hF, 3'b0, ~mdl_front, 13'b0});
        mdl_front = ~mdl_front;
    endtask

    // Scoreboard monitor: every nonzero bus word must be the next expected one.
    initial begin
        logic [31:0] exp;
        forever begin
            @(posedge clk);
            #2;
            if (!reset && cmd_out != 32'h0) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected", cmd_out, 32'h0);
                end else begin
                    exp = sb.pop_front();
                    check("sb_order", cmd_out, exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int budget;

        tbl[0] = '{32'h3802_0001, 32'h3802_0001};
        tbl[1] = '{32'hFC1C_1FFF, 32'hFC1C_1FFF};
        tbl[2] = '{32'h0000_0001, 32'h0000_0001};
        tbl[3] = '{32'hFFE3_FFFF, 32'hFFE3_FFFF};
        tbl[4] = '{32'h0402_4000, 32'h0402_4000};
        tbl[5] = '{32'h8000_0000, 32'h8000_0000};

        // Reset state
        repeat (3) step();
        check("rst_cmd_out", cmd_out, 32'h0);
        check("rst_front_buf", 32'(front_buf), 32'h0);
        check("rst_flip_pending", 32'(flip_pending), 32'h0);
        check("rst_waitrequest", 32'(waitrequest), 32'h0);
        check("rst_readdata", readdata, 32'h0);
        reset = 1'b0;
        step();

        // Latency N+2, held one cycle
        drive_write(32'h3802_00A5);
        sb.push_back(32'h3802_00A5);
        step();
        idle_bus();
        check("lat_n1", cmd_out, 32'h0);
        step();
        check("lat_n2", cmd_out, 32'h3802_00A5);
        step();
        check("lat_n3", cmd_out, 32'h0);

        // vblank outside FLIP_WAIT is ignored
        pulse_vblank();
        check("vb_idle_cmd", cmd_out, 32'h0);
        check("vb_idle_front", 32'(front_buf), 32'h0);
        restore_timing();
        step();

        // Table: back-to-back words at one per cycle
        for (int c = 0; c < NVEC + 2; c++) begin
            if (c < NVEC) begin
                drive_write(tbl[c].wdata);
                sb.push_back(tbl[c].exp_cmd);
            end else begin
                idle_bus();
            end
            check($sformatf("tbl_cyc%0d", c), cmd_out, (c >= 2) ? tbl[c-2].exp_cmd : 32'h0);
            step();
        end
        idle_bus();
        check("tbl_tail", cmd_out, 32'h0);
        step();

        // A, flip (junk payload), B
        drive_write(32'h3804_0011);
        sb.push_back(32'h3804_0011);
        step();
        drive_write(32'hA5BE_1234);
        expect_flip();
        step();
        drive_write(32'h3806_0022);
        sb.push_back(32'h3806_0022);
        check("flip_a_issue", cmd_out, 32'h3804_0011);
        check("flip_not_yet_pending", 32'(flip_pending), 32'h0);
        step();
        idle_bus();
        check("flip_pending_set", 32'(flip_pending), 32'h1);
        check("flip_wait_cmd", cmd_out, 32'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("flip_hold%0d", i), cmd_out, 32'h0);
        end
        check("flip_hold_pending", 32'(flip_pending), 32'h1);
        pulse_vblank();
        check("flush1_word", cmd_out, 32'h001E_2000);
        check("flush1_front", 32'(front_buf), 32'h1);
        check("flush1_pending", 32'(flip_pending), 32'h0);
        step();
        check("flip_b_issue", cmd_out, 32'h3806_0022);
        step();
        check("flip_b_done", cmd_out, 32'h0);
        restore_timing();

        // Second flip returns front_buf to 0
        drive_write(32'h03FF_FFFF);
        expect_flip();
        step();
        idle_bus();
        step();
        check("flip2_pending", 32'(flip_pending), 32'h1);
        repeat (3) step();
        pulse_vblank();
        check("flush2_word", cmd_out, 32'h001E_0000);
        check("flush2_front", 32'(front_buf), 32'h0);
        step();
        restore_timing();

        // Flip reaches head in the vblank_start cycle: waits a whole frame
        drive_write(32'h001E_0000);
        expect_flip();
        step();
        idle_bus();
        vcount = 10'd480;
        hcount = 10'd0;
        step();
        hcount = 10'd1;
        check("late_flip_pending", 32'(flip_pending), 32'h1);
        check("late_flip_cmd", cmd_out, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("late_hold%0d", i), cmd_out, 32'h0);
        end
        check("late_front_kept", 32'(front_buf), 32'h0);
        restore_timing();
        step();
        pulse_vblank();
        check("late_flush_word", cmd_out, 32'h001E_2000);
        check("late_flush_front", 32'(front_buf), 32'h1);
        step();
        restore_timing();

        // Reset with a pending flip and 5 queued words
        drive_write(32'h001E_0000);
        step();
        for (int i = 0; i < 5; i++) begin
            drive_write(32'h3802_0300 + 32'(i));
            step();
        end
        idle_bus();
        check("pre_rst_pending", 32'(flip_pending), 32'h1);
        #3;
        reset = 1'b1;
        #1;
        sb.delete();
        mdl_front = 1'b0;
        check("mid_rst_cmd", cmd_out, 32'h0);
        check("mid_rst_pending", 32'(flip_pending), 32'h0);
        check("mid_rst_front", 32'(front_buf), 32'h0);
        check("mid_rst_wait", 32'(waitrequest), 32'h0);
        step();
        step();
        reset = 1'b0;
        chipselect = 1'b1;
        read = 1'b1;
        step();
        idle_bus();
        check("post_rst_readdata", readdata, 32'h0);
        repeat (20) step();
        pulse_vblank();
        check("post_rst_no_flush", cmd_out, 32'h0);
        restore_timing();
        step();

        // Fill the FIFO while a flip is pending
        drive_write(32'h001E_0000);
        expect_flip();
        step();
        idle_bus();
        step();
        check("full_flip_pending", 32'(flip_pending), 32'h1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("full_wr%0d", i), 32'(waitrequest), 32'h0);
            drive_write(32'h3802_0100 + 32'(i));
            sb.push_back(32'h3802_0100 + 32'(i));
            step();
        end
        drive_write(32'h3802_0110);
        sb.push_back(32'h3802_0110);
        read = 1'b1;
        check("full_at16", 32'(waitrequest), 32'h1);
        step();
        read = 1'b0;
`ifdef SCHED_STATUS_READ_EN
        exp_status = 32'h0000_0210;
`else
        exp_status = 32'h0;
`endif
        check("full_status", readdata, exp_status);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("full_held%0d", i), 32'(waitrequest), 32'h1);
            step();
        end
        check("full_vb_cycle", 32'(waitrequest), 32'h1);
        pulse_vblank();
        check("full_flush_word", cmd_out, 32'h001E_2000);
        check("full_first_pop_wait", 32'(waitrequest), 32'h1);
        step();
        check("full_accept_wait", 32'(waitrequest), 32'h0);
        check("full_word0", cmd_out, 32'h3802_0100);
        step();
        idle_bus();
        restore_timing();
        budget = 0;
        while (sb.size() > 0 && budget < 100) begin
            step();
            budget++;
        end
        check("drain_empty", 32'(sb.size()), 32'h0);
        step();
        step();
        check("drain_idle", cmd_out, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_cmd_scheduler.md
# sprite_cmd_scheduler

Sequences sprite-update command words from the Avalon slave onto the broadcast command bus shared by all sprite display components (cloud, background and similar). Buffers software writes in a FIFO and issues at most one command per cycle. Owns the ping/pong front-buffer selection: a software flip request is held until the start of vertical blank, then emitted as a flush word so that all components switch buffers on the same cycle.

## Interface
- FIFO_DEPTH, 16: command FIFO depth in words; power of two, 4..64.
- VBLANK_LINE, 10'd480: vcount value at which the flip window opens.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- chipselect  in  1  Avalon slave select.
- write  in  1  Avalon write strobe.
- read  in  1  Avalon read strobe.
- writedata  in  32  command word: [31:26] component, [25:21] child, [20:17] info, [16:14] type, [13] buffer, [12:0] data.
- hcount  in  10  current pixel column from the VGA timing block.
- vcount  in  10  current line from the VGA timing block.
- waitrequest  out  1  high while the FIFO is full; the write must be held.
- readdata  out  32  status word (see Configuration).
- cmd_out  out  32  registered broadcast command; 32'h0 is a no-op (info=0).
- front_buf  out  1  currently displayed buffer index.
- flip_pending  out  1  flip request accepted and not yet issued.

## Operation
- Push: chipselect && write && !waitrequest, in any state. If info==4'hF the word is a flip request and is enqueued like any other command.
- Level: 0..FIFO_DEPTH. waitrequest = (level==FIFO_DEPTH). A write is never accepted when full, even if a pop occurs in the same cycle.
- vblank_start: a one-cycle pulse when vcount==VBLANK_LINE && hcount==0.
- IDLE: if FIFO empty, cmd_out<=0. Otherwise pop the head. If it is a normal word, cmd_out<=head and stay in ISSUE/IDLE. If it is a flip word, cmd_out<=0, flip_pending<=1, go to FLIP_WAIT.
- FLIP_WAIT: no pops, and commands behind the flip are held for the next frame. cmd_out<=0. On vblank_start go to FLIP_ISSUE.
- FLIP_ISSUE (exactly one cycle): cmd_out<={6'b0,5'b0,4'hF,3'b0,~front_buf,13'b0}, front_buf<=~front_buf, flip_pending<=0, then return to IDLE.
- Payload bits of a software flip word other than info are ignored.
- A vblank_start outside FLIP_WAIT has no effect.
- Arithmetic: level is $clog2(FIFO_DEPTH)+1 bits; read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: cmd_out=0, front_buf=0, flip_pending=0, waitrequest=0, readdata=0, level=0, state=IDLE.
- Latency: a word accepted in cycle N into an empty FIFO in IDLE appears on cmd_out in cycle N+2, held for exactly one cycle.
- Throughput: one word per cycle while the FIFO is non-empty and no flip is pending.
- Flip: the flush word appears on cmd_out in the cycle after the vblank_start cycle. front_buf toggles in that same cycle. If a flip word reaches the head during the vblank_start cycle, it waits for the next frame.
- Reset asserted mid-operation: FIFO contents are discarded, any pending flip is dropped, and cmd_out returns to 0 asynchronously.
- readdata is registered: valid in the cycle after chipselect && read.

## Configuration
- SCHED_STATUS_READ_EN defined: readdata = {16'b0, 6'b0, flip_pending, front_buf, level zero-extended to 8 bits}, updated on reads.
- SCHED_STATUS_READ_EN undefined: readdata is tied to 32'h0, the read port is ignored, and the status register is not built.

## Test plan
- Reset, then write 0x38020000|x0A5 (component 6'b001110, info 1) in cycle N: cmd_out equals that word in cycle N+2 only; cmd_out=0 otherwise.
- Write FIFO_DEPTH+1 words back-to-back in FLIP_WAIT: waitrequest rises after word 16, the 17th word is held, and it is accepted the cycle after the first pop following vblank.
- Write A, flip (info F), B at vcount=100: A issues; flip_pending=1; cmd_out=0 until vcount=480,hcount=0; next cycle cmd_out=0x001E2000, front_buf=1; B issues the following cycle.
- Second flip in the next frame: the flush word has bit13=0 and front_buf returns to 0.
- Flip word reaches head exactly at the vblank_start cycle: the flush is issued at the next frame's vblank, not the current one.
- Assert reset while 5 words are queued and flip_pending=1: level=0, flip_pending=0, front_buf=0, cmd_out=0; readdata=0 after a read (with SCHED_STATUS_READ_EN, readdata=0 reflects the cleared state).
